rvfi_bmc_sequencer: RTL and testbench
=====================================

// Module: rvfi_bmc_sequencer
// PURPOSE
// Formal-harness sequencer between the testbench clock and the core wrapper / rvfi_insn_check pair.
// Drives the active-high core reset and the one-shot checker enable at the BMC depth.
// Monitors the core's RVFI retirement stream: retirement count, rvfi_order continuity, sticky halt/trap flags.
// Replaces ad-hoc cycle/reset/enable logic in per-core insncheck harnesses.
// PARAMETERS
// NRET          1    retirement lanes on the RVFI bus
// RESET_CYCLES  5    cycles core_reset is held high after resetn releases; legal 1..BMC_DEPTH-1
// BMC_DEPTH     20   cycle at which the checker is armed; legal RESET_CYCLES+1..254
// PORTS
// clk             in   1         single clock, all logic posedge
// resetn          in   1         synchronous, active-low reset
// core_reset      out  1         active-high reset to core wrapper
// check_enable    out  1         one-cycle enable to rvfi_insn_check
// rvfi_valid      in   NRET      retirement valid per lane
// rvfi_order      in   64*NRET   retirement order per lane
// rvfi_trap       in   NRET      trap flag per lane
// rvfi_halt       in   NRET      halt flag per lane
// cycle           out  8         saturating cycle counter
// retire_count    out  16        retirements seen in RUN/CHECK, saturating
// order_error     out  1         sticky: order gap, lane hole, or retire during reset
// halt_seen       out  1         sticky: valid retirement with halt set
// trap_seen       out  1         sticky: valid retirement with trap set
// state           out  2         0=RESET_CORE 1=RUN 2=CHECK 3=DONE
// BEHAVIOUR
// Reset (resetn=0 at posedge), all registered:
//   cycle=0, core_reset=1, check_enable=0, retire_count=0, sticky flags=0, state=RESET_CORE, exp_order=0.
//   Applies identically mid-run; all history is discarded.
// cycle: +1 per clock after reset; saturates at 255 and holds.
// FSM, transitions on posedge; state and outputs registered:
//   RESET_CORE: core_reset=1. Leaves to RUN when cycle==RESET_CYCLES-1; core_reset drops with it.
//   RUN: leaves to CHECK when cycle==BMC_DEPTH-1.
//   CHECK: check_enable=1 for exactly this one cycle (cycle==BMC_DEPTH), then DONE.
//   DONE: terminal; check_enable=0; only resetn leaves it.
// Retirement monitor, active in RUN and CHECK only:
//   - Lanes must be packed: rvfi_valid[i] && !rvfi_valid[i-1] sets order_error.
//   - Each valid lane i must carry rvfi_order == exp_order + i; mismatch sets order_error.
//   - After the check, exp_order += popcount(rvfi_valid); 64-bit, wraps modulo 2^64.
//   - retire_count += popcount(rvfi_valid), saturating at 0xFFFF.
// rvfi_valid != 0 in RESET_CORE sets order_error. That retirement is neither counted nor advances exp_order.
// In DONE, RVFI inputs are ignored: no count, no flag updates.
// halt_seen / trap_seen: set when any valid lane has halt/trap; in RUN/CHECK only; cleared only by reset.
// An order mismatch and halt in the same lane set both flags in the same cycle.
// Sticky flags and counters update one cycle after the sampled retirement (registered).
// TESTING
// 1. resetn low 2 cycles, then high, no retirements:
//    -> core_reset=1 for cycles 0..4 and 0 from cycle 5; check_enable=1 only at cycle 20; state=DONE at 21.
// 2. NRET=1, orders 0,1,2 in RUN -> retire_count=3, order_error=0, exp_order=3.
// 3. NRET=1, orders 0,2 -> order_error=1 one cycle after order 2; retire_count=2; flag holds until resetn.
// 4. NRET=2, rvfi_valid=2'b10 -> order_error=1 (lane hole).
//    NRET=2, valid=2'b11, orders 4,5 with exp_order=4 -> retire_count +2, no error.
// 5. rvfi_valid=1 at cycle 2 (RESET_CORE) -> order_error=1, retire_count=0.
//    Retirement with halt=1 at cycle 10 -> halt_seen=1.
// 6. resetn pulsed low at cycle 12 (RUN) -> all outputs return to reset values; sequence restarts from cycle 0.
//    Also: hold 300 cycles -> cycle saturates at 255, state stays DONE.

Source files
------------

// File: rtl/rvfi_bmc_sequencer.sv
// Formal-harness sequencer: sequences core reset and the one-shot checker enable,
// and monitors the RVFI retirement stream for count, order continuity and halt/trap.
module rvfi_bmc_sequencer #(
    parameter int NRET         = 1,
    parameter int RESET_CYCLES = 5,
    parameter int BMC_DEPTH    = 20
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    output logic                 o_core_reset,
    output logic                 o_check_enable,
    input  logic [NRET-1:0]      i_rvfi_valid,
    input  logic [64*NRET-1:0]   i_rvfi_order,
    input  logic [NRET-1:0]      i_rvfi_trap,
    input  logic [NRET-1:0]      i_rvfi_halt,
    output logic [7:0]           o_cycle,
    output logic [15:0]          o_retire_count,
    output logic                 o_order_error,
    output logic                 o_halt_seen,
    output logic                 o_trap_seen,
    output logic [1:0]           o_state
);

    localparam logic [1:0] S_RESET_CORE = 2'd0;
    localparam logic [1:0] S_RUN        = 2'd1;
    localparam logic [1:0] S_CHECK      = 2'd2;
    localparam logic [1:0] S_DONE       = 2'd3;

    logic [1:0]  r_state;
    logic [7:0]  r_cycle;
    logic        r_core_reset;
    logic        r_check_enable;
    logic [15:0] r_retire_count;
    logic        r_order_error;
    logic        r_halt_seen;
    logic        r_trap_seen;
    logic [63:0] r_exp_order;

    logic        w_active;
    logic [15:0] w_pop;
    logic        w_bad;
    logic [16:0] w_sum;

    assign w_active = (r_state == S_RUN) || (r_state == S_CHECK);

    // Lane holes and per-lane order mismatches both fold into one error strobe.
    always_comb begin
        w_pop = 16'd0;
        w_bad = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            w_pop = w_pop + 16'(i_rvfi_valid[i]);
            if (i_rvfi_valid[i] && (i_rvfi_order[64*i +: 64] != r_exp_order + 64'(i)))
                w_bad = 1'b1;
        end
        for (int i = 1; i < NRET; i++) begin
            if (i_rvfi_valid[i] && !i_rvfi_valid[i-1])
                w_bad = 1'b1;
        end
    end

    assign w_sum = {1'b0, r_retire_count} + {1'b0, w_pop};

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state        <= S_RESET_CORE;
            r_cycle        <= 8'd0;
            r_core_reset   <= 1'b1;
            r_check_enable <= 1'b0;
            r_retire_count <= 16'd0;
            r_order_error  <= 1'b0;
            r_halt_seen    <= 1'b0;
            r_trap_seen    <= 1'b0;
            r_exp_order    <= 64'd0;
        end else begin
            if (r_cycle != 8'hFF)
                r_cycle <= r_cycle + 8'd1;

            case (r_state)
                S_RESET_CORE: begin
                    if (|i_rvfi_valid)
                        r_order_error <= 1'b1;
                    if (r_cycle == 8'(RESET_CYCLES - 1)) begin
                        r_state      <= S_RUN;
                        r_core_reset <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_cycle == 8'(BMC_DEPTH - 1)) begin
                        r_state        <= S_CHECK;
                        r_check_enable <= 1'b1;
                    end
                end
                S_CHECK: begin
                    r_state        <= S_DONE;
                    r_check_enable <= 1'b0;
                end
                default: begin
                    r_state        <= S_DONE;
                    r_check_enable <= 1'b0;
                end
            endcase

            if (w_active) begin
                if (w_bad)
                    r_order_error <= 1'b1;
                if (|(i_rvfi_valid & i_rvfi_halt))
                    r_halt_seen <= 1'b1;
                if (|(i_rvfi_valid & i_rvfi_trap))
                    r_trap_seen <= 1'b1;
                r_exp_order    <= r_exp_order + {48'd0, w_pop};
                r_retire_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
            end
        end
    end

    assign o_state        = r_state;
    assign o_cycle        = r_cycle;
    assign o_core_reset   = r_core_reset;
    assign o_check_enable = r_check_enable;
    assign o_retire_count = r_retire_count;
    assign o_order_error  = r_order_error;
    assign o_halt_seen    = r_halt_seen;
    assign o_trap_seen    = r_trap_seen;

endmodule

// File: tb/tb_rvfi_bmc_sequencer.sv
// Randomized bench for rvfi_bmc_sequencer: one NRET=1 and one NRET=2 instance share
// clock and reset; a cycle-indexed reference model predicts every output each cycle.
module tb_rvfi_bmc_sequencer;

    localparam int RC = 5;
    localparam int BD = 20;

    logic         clk;
    logic         resetn;

    logic [0:0]   v1, h1, t1;
    logic [63:0]  o1;
    logic [1:0]   v2, h2, t2;
    logic [127:0] o2;

    logic         cr1, ce1, oe1, hs1, ts1;
    logic [7:0]   cyc1;
    logic [15:0]  rc1;
    logic [1:0]   st1;
    logic         cr2, ce2, oe2, hs2, ts2;
    logic [7:0]   cyc2;
    logic [15:0]  rc2;
    logic [1:0]   st2;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cycles since reset plus retirement history per instance.
    int              m_c;
    longint unsigned m_e[2];
    int              m_cnt[2];
    bit              m_oe[2], m_hs[2], m_ts[2];

    rvfi_bmc_sequencer #(.NRET(1), .RESET_CYCLES(RC), .BMC_DEPTH(BD)) u_dut1 (
        .i_clk(clk), .i_resetn(resetn),
        .o_core_reset(cr1), .o_check_enable(ce1),
        .i_rvfi_valid(v1), .i_rvfi_order(o1), .i_rvfi_trap(t1), .i_rvfi_halt(h1),
        .o_cycle(cyc1), .o_retire_count(rc1), .o_order_error(oe1),
        .o_halt_seen(hs1), .o_trap_seen(ts1), .o_state(st1)
    );

    rvfi_bmc_sequencer #(.NRET(2), .RESET_CYCLES(RC), .BMC_DEPTH(BD)) u_dut2 (
        .i_clk(clk), .i_resetn(resetn),
        .o_core_reset(cr2), .o_check_enable(ce2),
        .i_rvfi_valid(v2), .i_rvfi_order(o2), .i_rvfi_trap(t2), .i_rvfi_halt(h2),
        .o_cycle(cyc2), .o_retire_count(rc2), .o_order_error(oe2),
        .o_halt_seen(hs2), .o_trap_seen(ts2), .o_state(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (model cycle %0d)", tag, obs, exp, m_c);
        end
    endtask

    function automatic int exp_state(input int c);
        if (c < RC)       return 0;
        else if (c < BD)  return 1;
        else if (c == BD) return 2;
        else              return 3;
    endfunction

    task automatic model_reset();
        m_c = 0;
        for (int k = 0; k < 2; k++) begin
            m_e[k] = 0; m_cnt[k] = 0; m_oe[k] = 0; m_hs[k] = 0; m_ts[k] = 0;
        end
    endtask

    // Packed lanes means valid is of the form 2^n-1; retired orders must be e, e+1, ...
    task automatic model_step(input int k, input int n, input logic [1:0] v,
                              input logic [127:0] o, input logic [1:0] h, input logic [1:0] t);
        int s;
        int pop;
        s = exp_state(m_c);
        pop = $countones(v);
        if (s == 0 && v != 0) m_oe[k] = 1;
        if (s == 1 || s == 2) begin
            if ((v & (v + 2'd1)) != 0) m_oe[k] = 1;
            for (int i = 0; i < n; i++) begin
                if (v[i]) begin
                    if (o[64*i +: 64] != m_e[k] + longint'(i)) m_oe[k] = 1;
                    if (h[i]) m_hs[k] = 1;
                    if (t[i]) m_ts[k] = 1;
                end
            end
            m_e[k] = m_e[k] + longint'(pop);
            m_cnt[k] = (m_cnt[k] + pop > 65535) ? 65535 : m_cnt[k] + pop;
        end
    endtask

    task automatic compare(input string p, input int k, input logic [7:0] cyc, input logic [1:0] st,
                           input logic cr, input logic ce, input logic [15:0] rc,
                           input logic oe, input logic hs, input logic ts);
        check({p, "_cycle"},        64'(cyc), 64'((m_c > 255) ? 255 : m_c));
        check({p, "_state"},        64'(st),  64'(exp_state(m_c)));
        check({p, "_core_reset"},   64'(cr),  64'(m_c < RC));
        check({p, "_check_enable"}, 64'(ce),  64'(m_c == BD));
        check({p, "_retire_count"}, 64'(rc),  64'(m_cnt[k]));
        check({p, "_order_error"},  64'(oe),  64'(m_oe[k]));
        check({p, "_halt_seen"},    64'(hs),  64'(m_hs[k]));
        check({p, "_trap_seen"},    64'(ts),  64'(m_ts[k]));
    endtask

    // mode 0: no retirements; 1: well-formed stream; 2: includes faults
    task automatic gen(input int n, input longint unsigned e, input int mode,
                       output logic [1:0] v, output logic [127:0] o,
                       output logic [1:0] h, output logic [1:0] t);
        int s;
        int cnt;
        s = exp_state(m_c);
        v = 2'b00;
        o = {$urandom, $urandom, $urandom, $urandom};
        h = 2'b00;
        t = 2'b00;
        if (mode == 0) return;
        if (s != 0 && $urandom_range(0, 99) < 55) begin
            cnt = $urandom_range(1, n);
            v = (cnt == 2) ? 2'b11 : 2'b01;
            for (int i = 0; i < n; i++) o[64*i +: 64] = e + longint'(i);
        end
        if (mode == 2) begin
            if (s == 0 && $urandom_range(0, 99) < 10) v = 2'b01;
            if (n == 2 && $urandom_range(0, 99) < 6) v = 2'b10;
            if ($urandom_range(0, 99) < 6) o[63:0] = o[63:0] + 64'($urandom_range(1, 3));
            if (s == 3) o = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int i = 0; i < n; i++) begin
            h[i] = ($urandom_range(0, 99) < 4);
            t[i] = ($urandom_range(0, 99) < 4);
        end
    endtask

    task automatic step(input logic rst_n, input int mode);
        logic [1:0]   v, h, t;
        logic [127:0] o;
        @(negedge clk);
        resetn = rst_n;
        gen(1, m_e[0], mode, v, o, h, t);
        v1 = v[0:0]; o1 = o[63:0]; h1 = h[0:0]; t1 = t[0:0];
        gen(2, m_e[1], mode, v2, o2, h2, t2);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, 1, {1'b0, v1}, {64'd0, o1}, {1'b0, h1}, {1'b0, t1});
            model_step(1, 2, v2, o2, h2, t2);
            m_c++;
        end
        #1;
        compare("n1", 0, cyc1, st1, cr1, ce1, rc1, oe1, hs1, ts1);
        compare("n2", 1, cyc2, st2, cr2, ce2, rc2, oe2, hs2, ts2);
    endtask

    task automatic episode(input int len, input int mode);
        step(1'b0, 0);
        step(1'b0, 0);
        for (int i = 0; i < len; i++) step(1'b1, mode);
    endtask

    initial begin
        resetn = 1'b0;
        v1 = '0; o1 = '0; h1 = '0; t1 = '0;
        v2 = '0; o2 = '0; h2 = '0; t2 = '0;
        model_reset();

        episode(25, 0);
        episode(12, 1);
        for (int ep = 0; ep < 40; ep++)
            episode($urandom_range(3, 45), $urandom_range(1, 2));
        episode(300, 1);
        episode(30, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
